// File: rtl/dbuf_filt.sv
// Multi-channel input buffer: 2-flop synchronizer plus per-channel deglitch counter.
// Optional change-pulse output is built only when DBUF_FILT_CHG_EN is defined.
module dbuf_filt #(
    parameter int unsigned             WIDTH   = 4,
    parameter int unsigned             FILT    = 3,
    parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
    input  logic             CELCLK,
    input  logic             CELRST,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] chg
);

    localparam int unsigned CW = (FILT < 2) ? 1 : $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_MAX = (FILT == 0) ? '0 : CW'(FILT - 1);

    // Supply/substrate pins exist for connectivity only.
    logic w_unused_supply;
    assign w_unused_supply = CELV & CELG & SUB;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] w_o_d;
    logic [CW-1:0]    r_cnt   [WIDTH];
    logic [CW-1:0]    w_cnt_d [WIDTH];

    always_comb begin
        w_o_d = r_o;
        for (int n = 0; n < WIDTH; n++) begin
            w_cnt_d[n] = r_cnt[n];
            if (!en || (r_s2[n] == r_o[n])) begin
                w_cnt_d[n] = '0;
            end else if ((FILT == 0) || (r_cnt[n] == CNT_MAX)) begin
                w_o_d[n]   = r_s2[n];
                w_cnt_d[n] = '0;
            end else begin
                w_cnt_d[n] = r_cnt[n] + CW'(1);
            end
        end
    end

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_o  <= RST_VAL;
            for (int n = 0; n < WIDTH; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            r_s1 <= i;
            r_s2 <= r_s1;
            r_o  <= w_o_d;
            for (int n = 0; n < WIDTH; n++) begin
                r_cnt[n] <= w_cnt_d[n];
            end
        end
    end

    assign o = r_o;

`ifdef DBUF_FILT_CHG_EN
    // Delayed copy of o; the XOR is high for the single cycle after o moves.
    logic [WIDTH-1:0] r_o_prev;

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            r_o_prev <= RST_VAL;
        end else begin
            r_o_prev <= r_o;
        end
    end

    assign chg = r_o ^ r_o_prev;
`else
    assign chg = '0;
`endif

endmodule

// File: tb/tb_dbuf_filt.sv
// Self-checking bench for dbuf_filt: three instances (FILT=3, FILT=0, RST_VAL=5)
// share stimulus; per-edge expectations flow through a scoreboard queue.
module tb_dbuf_filt;

    logic       CELCLK;
    logic       CELRST;
    logic       CELV;
    logic       CELG;
    logic       SUB;
    logic       en;
    logic [3:0] i;
    logic [3:0] o_a, o_b, o_c;
    logic [3:0] chg_a, chg_b, chg_c;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] chg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    dbuf_filt #(.WIDTH(4), .FILT(3), .RST_VAL(4'h0)) u_a (
        .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .i(i), .o(o_a), .chg(chg_a)
    );

    dbuf_filt #(.WIDTH(4), .FILT(0), .RST_VAL(4'h0)) u_b (
        .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .i(i), .o(o_b), .chg(chg_b)
    );

    dbuf_filt #(.WIDTH(4), .FILT(3), .RST_VAL(4'h5)) u_c (
        .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .i(i), .o(o_c), .chg(chg_c)
    );

    initial CELCLK = 1'b0;
    always #5 CELCLK = ~CELCLK;

    // Expected change pulse given this edge's and the previous edge's expected o.
    function automatic logic [3:0] chg_exp(input logic [3:0] cur, input logic [3:0] prev);
`ifdef DBUF_FILT_CHG_EN
        return cur ^ prev;
`else
        return 4'h0 & (cur ^ prev);
`endif
    endfunction

    task automatic settle();
        CELRST = 1'b1;
        en     = 1'b1;
        i      = 4'h0;
        @(posedge CELCLK); #1;
        CELRST = 1'b0;
        repeat (8) @(posedge CELCLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] prev;
        CELRST = 1'b1;
        en     = 1'b1;
        i      = 4'h0;
        @(posedge CELCLK); #1;
        n_checks++;
        if (o_a !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_o_a: got %h want 0", o_a);
        end
        n_checks++;
        if (o_b !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_o_b: got %h want 0", o_b);
        end
        n_checks++;
        if (o_c !== 4'h5) begin
            n_errors++;
            $display("FAIL reset_o_c: got %h want 5", o_c);
        end
        n_checks++;
        if ((chg_a !== 4'h0) || (chg_c !== 4'h0)) begin
            n_errors++;
            $display("FAIL reset_chg: got %h/%h want 0/0", chg_a, chg_c);
        end
        // After release o_c walks from RST_VAL to the sampled 0 after 2+FILT edges.
        CELRST = 1'b0;
        prev   = 4'h5;
        for (int k = 0; k < 7; k++) begin
            e.o   = (k >= 4) ? 4'h0 : 4'h5;
            e.chg = chg_exp(e.o, prev);
            prev  = e.o;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_c !== e.o) begin
                n_errors++;
                $display("FAIL rstval_o edge %0d: got %h want %h", k, o_c, e.o);
            end
            n_checks++;
            if (chg_c !== e.chg) begin
                n_errors++;
                $display("FAIL rstval_chg edge %0d: got %h want %h", k, chg_c, e.chg);
            end
        end
    endtask

    task automatic test_rise();
        exp_t e;
        logic [3:0] prev = 4'h0;
        settle();
        for (int k = 0; k < 8; k++) begin
            i     = 4'h1;
            e.o   = (k >= 4) ? 4'h1 : 4'h0;
            e.chg = chg_exp(e.o, prev);
            prev  = e.o;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_a !== e.o) begin
                n_errors++;
                $display("FAIL rise_o edge %0d: got %h want %h", k, o_a, e.o);
            end
            n_checks++;
            if (chg_a !== e.chg) begin
                n_errors++;
                $display("FAIL rise_chg edge %0d: got %h want %h", k, chg_a, e.chg);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        settle();
        for (int k = 0; k < 10; k++) begin
            i     = (k < 2) ? 4'h2 : 4'h0;
            e.o   = 4'h0;
            e.chg = 4'h0;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if ((o_a !== e.o) || (chg_a !== e.chg)) begin
                n_errors++;
                $display("FAIL glitch edge %0d: got o=%h chg=%h want o=%h chg=%h",
                         k, o_a, chg_a, e.o, e.chg);
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        logic [3:0] prev = 4'h0;
        settle();
        for (int k = 0; k < 14; k++) begin
            i     = 4'hF;
            en    = ((k >= 3) && (k < 8)) ? 1'b0 : 1'b1;
            e.o   = (k >= 10) ? 4'hF : 4'h0;
            e.chg = chg_exp(e.o, prev);
            prev  = e.o;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_a !== e.o) begin
                n_errors++;
                $display("FAIL enable_o edge %0d: got %h want %h", k, o_a, e.o);
            end
            n_checks++;
            if (chg_a !== e.chg) begin
                n_errors++;
                $display("FAIL enable_chg edge %0d: got %h want %h", k, chg_a, e.chg);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_rst_mid();
        exp_t e;
        settle();
        for (int k = 0; k < 13; k++) begin
            i      = 4'h4;
            CELRST = (k == 4);
            e.o    = (k >= 9) ? 4'h4 : 4'h0;
            e.chg  = 4'h0;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_a !== e.o) begin
                n_errors++;
                $display("FAIL rst_mid_o edge %0d: got %h want %h", k, o_a, e.o);
            end
        end
        CELRST = 1'b0;
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [3:0] prev = 4'h0;
        settle();
        for (int k = 0; k < 6; k++) begin
            i     = 4'hA;
            e.o   = (k >= 2) ? 4'hA : 4'h0;
            e.chg = chg_exp(e.o, prev);
            prev  = e.o;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_b !== e.o) begin
                n_errors++;
                $display("FAIL bypass_o edge %0d: got %h want %h", k, o_b, e.o);
            end
            n_checks++;
            if (chg_b !== e.chg) begin
                n_errors++;
                $display("FAIL bypass_chg edge %0d: got %h want %h", k, chg_b, e.chg);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] prev = 4'h0;
        settle();
        for (int k = 0; k < 10; k++) begin
            i     = (k >= 2) ? 4'h3 : 4'h1;
            e.o   = (k >= 6) ? 4'h3 : ((k >= 4) ? 4'h1 : 4'h0);
            e.chg = chg_exp(e.o, prev);
            prev  = e.o;
            sb.push_back(e);
            @(posedge CELCLK); #1;
            e = sb.pop_front();
            n_checks++;
            if (o_a !== e.o) begin
                n_errors++;
                $display("FAIL b2b_o edge %0d: got %h want %h", k, o_a, e.o);
            end
            n_checks++;
            if (chg_a !== e.chg) begin
                n_errors++;
                $display("FAIL b2b_chg edge %0d: got %h want %h", k, chg_a, e.chg);
            end
        end
    endtask

    initial begin
        CELRST = 1'b1;
        CELV   = 1'b1;
        CELG   = 1'b0;
        SUB    = 1'b0;
        en     = 1'b1;
        i      = 4'h0;
        test_reset();
        test_rise();
        test_glitch();
        test_enable();
        test_rst_mid();
        test_bypass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
